song_tutor_ctrl: RTL and testbench
==================================

// Module: song_tutor_ctrl
// PURPOSE
//  Sequences a note-by-note song lesson for the piano: holds a small song ROM
//  (4 songs), drives the 8-bit Led pattern of the next expected note, advances
//  on press-then-release of the correct key, counts wrong presses, and flags completion.
//  Sits between the key decoder (4-bit note code) and the board LEDs.
//  Supersedes per-song hard-coded tutor FSMs.
// PARAMETERS
//  HINT_TICKS  8   TICK strobes spent in WAIT_PRESS before hint blink starts (HINT_BLINK_EN only)
//  MAX_MISS    255 saturation value of mistakes counter (must be <= 255)
// PORTS
//  CLK       in  1  system clock
//  RESET     in  1  asynchronous, active-high reset
//  TICK      in  1  one-CLK strobe, slow timebase (~4 Hz) used for hint timing
//  note      in  4  current key code (codes C4,D,E,F,G,none from parameters.v)
//  song_sel  in  2  song index, sampled only on accepted start
//  start     in  1  begin lesson (level; accepted only in IDLE or DONE)
//  abort     in  1  cancel lesson, return to IDLE
//  Led       out 8  expected-note pattern (_C4.._G from parameters.v), 0 idle, 8'hFF done
//  busy      out 1  high in WAIT_PRESS / WAIT_RELEASE
//  song_done out 1  one-CLK pulse on final note release
//  note_idx  out 5  index of expected note within song
//  mistakes  out 8  wrong-press count for current lesson
// BEHAVIOUR
//  Reset: state=IDLE, Led=0, busy=0, song_done=0, note_idx=0, mistakes=0, wait_cnt=0.
//  Song ROM (note codes, LEN = length):
//   0: E E F G G F E D C4 C4 D E E D D (15)   1: E D C4 D E E E D D D E G G (13)
//   2: C4 D E F G F E D C4 (9)                3: G F E D C4 (5)
//  FSM states: IDLE, WAIT_PRESS, WAIT_RELEASE, DONE.
//   IDLE/DONE: start=1 -> latch song_sel, note_idx=0, mistakes=0, -> WAIT_PRESS.
//   WAIT_PRESS: note==expected -> WAIT_RELEASE; else on wrong press event
//     mistakes+=1 (saturate MAX_MISS). Wrong press event = note!=none && note!=prev_note.
//     A key already held equal to expected at entry is accepted immediately.
//   WAIT_RELEASE: note==none -> if note_idx==LEN-1: DONE, song_done=1 for 1 cycle;
//     else note_idx+=1, -> WAIT_PRESS. Wrong notes here are not counted.
//   DONE: holds note_idx=LEN-1 and mistakes until next start or abort (abort -> IDLE).
//  abort (any state but IDLE) -> IDLE next cycle; wins over start and over
//   completion in the same cycle (no song_done pulse). In IDLE, start wins.
//  start while busy: ignored. song_sel changes after start: ignored.
//  prev_note register updated every cycle; reset to none.
//  Led registered: reflects state/note_idx of previous cycle (1-cycle latency);
//   WAIT_* -> pattern of ROM[song][note_idx]; IDLE -> 0; DONE -> 8'hFF.
//  busy/note_idx/mistakes are direct register outputs (same cycle as state).
//  wait_cnt: cleared on entering WAIT_PRESS, +1 per TICK in WAIT_PRESS, saturates at HINT_TICKS.
// CONFIGURATION
//  HINT_BLINK_EN defined: in WAIT_PRESS with wait_cnt==HINT_TICKS, Led toggles between
//   pattern and 0 on each TICK (first TICK after saturation -> 0); any state change
//   restores steady pattern next cycle.
//  HINT_BLINK_EN undefined: wait_cnt logic absent; Led steady; TICK unused.
// TESTING
//  1 RESET mid-lesson (song 0, idx 5) -> all outputs 0, state IDLE same cycle as RESET.
//  2 start, song_sel=2; play C4,none,D,none,...,C4,none -> note_idx 0..8, song_done one
//    pulse after last none, Led=8'hFF, mistakes=0, busy=0.
//  3 song 3 idx 0 expects G: play E,none,F,none,G,none -> mistakes=2, note_idx=1;
//    held E for 50 cycles counts 1.
//  4 song 1 at last note: abort same cycle as final none -> IDLE, no song_done, Led=0.
//  5 start while busy with song_sel changed -> ignored, note_idx/mistakes unchanged;
//    300 wrong presses -> mistakes=255.
//  6 HINT_BLINK_EN, HINT_TICKS=8: no key 8 TICKs -> Led toggles 0/pattern per TICK;
//    correct press -> steady pattern; without macro Led stays steady throughout.

Source files
------------

// File: rtl/song_tutor_ctrl.sv
// Note-by-note piano lesson sequencer: a 4-song ROM, an expected-note LED, a miss counter and a completion pulse.
// Optional hint blink on the expected-note LED is enabled by defining HINT_BLINK_EN.
module song_tutor_ctrl #(
  parameter int HINT_TICKS = 8,
  parameter int MAX_MISS   = 255
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic       TICK,
  input  logic [3:0] note,
  input  logic [1:0] song_sel,
  input  logic       start,
  input  logic       abort,
  output logic [7:0] Led,
  output logic       busy,
  output logic       song_done,
  output logic [4:0] note_idx,
  output logic [7:0] mistakes
);

  // Key codes and LED patterns shared with the key decoder / board
  localparam logic [3:0] N_NONE = 4'd0;
  localparam logic [3:0] N_C4   = 4'd1;
  localparam logic [3:0] N_D    = 4'd2;
  localparam logic [3:0] N_E    = 4'd3;
  localparam logic [3:0] N_F    = 4'd4;
  localparam logic [3:0] N_G    = 4'd5;

  localparam logic [7:0] L_C4   = 8'h01;
  localparam logic [7:0] L_D    = 8'h02;
  localparam logic [7:0] L_E    = 8'h04;
  localparam logic [7:0] L_F    = 8'h08;
  localparam logic [7:0] L_G    = 8'h10;

  localparam logic [7:0] MISS_SAT = 8'(MAX_MISS);

  typedef enum logic [1:0] {IDLE, WAIT_PRESS, WAIT_RELEASE, DONE} state_t;

  function automatic logic [3:0] rom_note(input logic [1:0] s, input logic [4:0] i);
    logic [3:0] n;
    n = N_NONE;
    case (s)
      2'd0: case (i)
        5'd0, 5'd1, 5'd6, 5'd11, 5'd12: n = N_E;
        5'd2, 5'd5:                     n = N_F;
        5'd3, 5'd4:                     n = N_G;
        5'd7, 5'd10, 5'd13, 5'd14:      n = N_D;
        5'd8, 5'd9:                     n = N_C4;
        default:                        n = N_NONE;
      endcase
      2'd1: case (i)
        5'd0, 5'd4, 5'd5, 5'd6, 5'd10:  n = N_E;
        5'd1, 5'd3, 5'd7, 5'd8, 5'd9:   n = N_D;
        5'd2:                           n = N_C4;
        5'd11, 5'd12:                   n = N_G;
        default:                        n = N_NONE;
      endcase
      2'd2: case (i)
        5'd0, 5'd8:                     n = N_C4;
        5'd1, 5'd7:                     n = N_D;
        5'd2, 5'd6:                     n = N_E;
        5'd3, 5'd5:                     n = N_F;
        5'd4:                           n = N_G;
        default:                        n = N_NONE;
      endcase
      default: case (i)
        5'd0:                           n = N_G;
        5'd1:                           n = N_F;
        5'd2:                           n = N_E;
        5'd3:                           n = N_D;
        5'd4:                           n = N_C4;
        default:                        n = N_NONE;
      endcase
    endcase
    return n;
  endfunction

  function automatic logic [4:0] rom_last(input logic [1:0] s);
    case (s)
      2'd0:    return 5'd14;
      2'd1:    return 5'd12;
      2'd2:    return 5'd8;
      default: return 5'd4;
    endcase
  endfunction

  function automatic logic [7:0] pattern(input logic [3:0] n);
    case (n)
      N_C4:    return L_C4;
      N_D:     return L_D;
      N_E:     return L_E;
      N_F:     return L_F;
      N_G:     return L_G;
      default: return 8'h00;
    endcase
  endfunction

  state_t     state, state_nxt;
  logic [1:0] song, song_nxt;
  logic [4:0] idx_nxt;
  logic [7:0] miss_nxt;
  logic       done_nxt;
  logic [3:0] prev_note;
  logic [3:0] expected;

  assign expected = rom_note(song, note_idx);

  always_comb begin
    state_nxt = state;
    song_nxt  = song;
    idx_nxt   = note_idx;
    miss_nxt  = mistakes;
    done_nxt  = 1'b0;
    case (state)
      IDLE, DONE: begin
        // abort is a no-op in IDLE, so start only loses to it from DONE
        if (abort && state == DONE) begin
          state_nxt = IDLE;
        end else if (start) begin
          song_nxt  = song_sel;
          idx_nxt   = 5'd0;
          miss_nxt  = 8'd0;
          state_nxt = WAIT_PRESS;
        end
      end
      WAIT_PRESS: begin
        if (abort) begin
          state_nxt = IDLE;
        end else if (note == expected) begin
          state_nxt = WAIT_RELEASE;
        end else if (note != N_NONE && note != prev_note && mistakes != MISS_SAT) begin
          miss_nxt = mistakes + 8'd1;
        end
      end
      WAIT_RELEASE: begin
        if (abort) begin
          state_nxt = IDLE;
        end else if (note == N_NONE) begin
          if (note_idx == rom_last(song)) begin
            state_nxt = DONE;
            done_nxt  = 1'b1;
          end else begin
            idx_nxt   = note_idx + 5'd1;
            state_nxt = WAIT_PRESS;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  logic blink_off;

`ifdef HINT_BLINK_EN
  localparam int WW = $clog2(HINT_TICKS + 1);
  localparam logic [WW-1:0] WAIT_SAT = WW'(HINT_TICKS);
  logic [WW-1:0] wait_cnt;

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      wait_cnt  <= '0;
      blink_off <= 1'b0;
    end else begin
      if (state != WAIT_PRESS && state_nxt == WAIT_PRESS)
        wait_cnt <= '0;
      else if (state == WAIT_PRESS && TICK && wait_cnt != WAIT_SAT)
        wait_cnt <= wait_cnt + 1'b1;
      // Any departure from WAIT_PRESS drops the blink so the pattern comes back steady
      if (state != WAIT_PRESS || state_nxt != WAIT_PRESS)
        blink_off <= 1'b0;
      else if (TICK && wait_cnt == WAIT_SAT)
        blink_off <= ~blink_off;
    end
  end
`else
  logic unused_tick;
  assign unused_tick = TICK;
  assign blink_off   = 1'b0;
`endif

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state     <= IDLE;
      song      <= 2'd0;
      note_idx  <= 5'd0;
      mistakes  <= 8'd0;
      busy      <= 1'b0;
      song_done <= 1'b0;
      prev_note <= N_NONE;
      Led       <= 8'h00;
    end else begin
      state     <= state_nxt;
      song      <= song_nxt;
      note_idx  <= idx_nxt;
      mistakes  <= miss_nxt;
      busy      <= (state_nxt == WAIT_PRESS) || (state_nxt == WAIT_RELEASE);
      song_done <= done_nxt;
      prev_note <= note;
      // LED follows the state one cycle behind
      case (state)
        WAIT_PRESS, WAIT_RELEASE: Led <= blink_off ? 8'h00 : pattern(expected);
        DONE:                     Led <= 8'hFF;
        default:                  Led <= 8'h00;
      endcase
    end
  end

endmodule

// File: tb/tb_song_tutor_ctrl.sv
// Directed bench for song_tutor_ctrl: reset, full lessons, miss counting, abort, busy-start and hint LED.
module tb_song_tutor_ctrl;

  localparam logic [3:0] NONE = 4'd0;
  localparam logic [3:0] C4   = 4'd1;
  localparam logic [3:0] D    = 4'd2;
  localparam logic [3:0] E    = 4'd3;
  localparam logic [3:0] F    = 4'd4;
  localparam logic [3:0] G    = 4'd5;

  logic       CLK = 1'b0;
  logic       RESET = 1'b1;
  logic       TICK = 1'b0;
  logic [3:0] note = 4'd0;
  logic [1:0] song_sel = 2'd0;
  logic       start = 1'b0;
  logic       abort = 1'b0;
  logic [7:0] Led;
  logic       busy;
  logic       song_done;
  logic [4:0] note_idx;
  logic [7:0] mistakes;

  int total = 0;
  int bad = 0;

  logic [3:0] s0[15] = '{E, E, F, G, G, F, E, D, C4, C4, D, E, E, D, D};
  logic [3:0] s1[13] = '{E, D, C4, D, E, E, E, D, D, D, E, G, G};
  logic [3:0] s2[9]  = '{C4, D, E, F, G, F, E, D, C4};

  song_tutor_ctrl #(.HINT_TICKS(8), .MAX_MISS(255)) dut (
    .CLK(CLK), .RESET(RESET), .TICK(TICK), .note(note), .song_sel(song_sel),
    .start(start), .abort(abort), .Led(Led), .busy(busy), .song_done(song_done),
    .note_idx(note_idx), .mistakes(mistakes)
  );

  always #5 CLK = ~CLK;

  task automatic cyc();
    @(posedge CLK);
    #1;
  endtask

  task automatic play(input logic [3:0] n);
    note = n;
    cyc();
    note = NONE;
    cyc();
  endtask

  task automatic begin_song(input logic [1:0] s);
    song_sel = s;
    start = 1'b1;
    cyc();
    start = 1'b0;
  endtask

  task automatic do_abort();
    abort = 1'b1;
    cyc();
    abort = 1'b0;
    cyc();
  endtask

  task automatic test_reset();
    RESET = 1'b1;
    cyc();
    cyc();
    if ({Led, busy, song_done, note_idx, mistakes} !== 23'd0) begin
      $display("FAIL reset_outputs got=%h exp=0", {Led, busy, song_done, note_idx, mistakes});
      bad++;
    end
    total++;
    RESET = 1'b0;
    cyc();
  endtask

  task automatic test_reset_mid_lesson();
    begin_song(2'd0);
    for (int i = 0; i < 5; i++) play(s0[i]);
    if (note_idx !== 5'd5 || busy !== 1'b1 || Led !== 8'h10) begin
      $display("FAIL mid_lesson_pre idx=%0d busy=%0b led=%h exp idx=5 busy=1 led=10", note_idx, busy, Led);
      bad++;
    end
    total++;
    #2 RESET = 1'b1;
    #1;
    if ({Led, busy, song_done, note_idx, mistakes} !== 23'd0) begin
      $display("FAIL mid_lesson_reset got=%h exp=0", {Led, busy, song_done, note_idx, mistakes});
      bad++;
    end
    total++;
    cyc();
    RESET = 1'b0;
    cyc();
  endtask

  task automatic test_full_song2();
    begin_song(2'd2);
    cyc();
    if (Led !== 8'h01 || busy !== 1'b1) begin
      $display("FAIL song2_first_led led=%h busy=%0b exp led=01 busy=1", Led, busy);
      bad++;
    end
    total++;
    for (int i = 0; i < 8; i++) begin
      play(s2[i]);
      if (note_idx !== 5'(i + 1)) begin
        $display("FAIL song2_idx step=%0d got=%0d exp=%0d", i, note_idx, i + 1);
        bad++;
      end
      total++;
    end
    play(s2[8]);
    if (song_done !== 1'b1 || busy !== 1'b0 || note_idx !== 5'd8 || mistakes !== 8'd0) begin
      $display("FAIL song2_done done=%0b busy=%0b idx=%0d miss=%0d exp 1 0 8 0",
               song_done, busy, note_idx, mistakes);
      bad++;
    end
    total++;
    cyc();
    if (song_done !== 1'b0 || Led !== 8'hFF || note_idx !== 5'd8) begin
      $display("FAIL song2_after done=%0b led=%h idx=%0d exp 0 ff 8", song_done, Led, note_idx);
      bad++;
    end
    total++;
  endtask

  task automatic test_back_to_back();
    // still in DONE from the previous lesson: abort beats start
    song_sel = 2'd3;
    start = 1'b1;
    abort = 1'b1;
    cyc();
    start = 1'b0;
    abort = 1'b0;
    cyc();
    if (busy !== 1'b0 || Led !== 8'h00) begin
      $display("FAIL done_abort_wins busy=%0b led=%h exp 0 00", busy, Led);
      bad++;
    end
    total++;
    begin_song(2'd3);
    if (busy !== 1'b1 || note_idx !== 5'd0 || mistakes !== 8'd0) begin
      $display("FAIL restart busy=%0b idx=%0d miss=%0d exp 1 0 0", busy, note_idx, mistakes);
      bad++;
    end
    total++;
    do_abort();
  endtask

  task automatic test_mistakes();
    begin_song(2'd3);
    play(E);
    play(F);
    play(G);
    if (mistakes !== 8'd2 || note_idx !== 5'd1) begin
      $display("FAIL miss_count miss=%0d idx=%0d exp 2 1", mistakes, note_idx);
      bad++;
    end
    total++;
    note = E;
    for (int i = 0; i < 50; i++) cyc();
    note = NONE;
    cyc();
    if (mistakes !== 8'd3 || note_idx !== 5'd1) begin
      $display("FAIL miss_held miss=%0d idx=%0d exp 3 1", mistakes, note_idx);
      bad++;
    end
    total++;
    do_abort();
  endtask

  task automatic test_abort_at_end();
    begin_song(2'd1);
    for (int i = 0; i < 12; i++) play(s1[i]);
    note = G;
    cyc();
    note = NONE;
    abort = 1'b1;
    cyc();
    abort = 1'b0;
    if (song_done !== 1'b0 || busy !== 1'b0) begin
      $display("FAIL abort_last done=%0b busy=%0b exp 0 0", song_done, busy);
      bad++;
    end
    total++;
    cyc();
    if (Led !== 8'h00 || song_done !== 1'b0) begin
      $display("FAIL abort_last_led led=%h done=%0b exp 00 0", Led, song_done);
      bad++;
    end
    total++;
  endtask

  task automatic test_busy_start_saturate();
    begin_song(2'd0);
    play(E);
    song_sel = 2'd3;
    start = 1'b1;
    cyc();
    cyc();
    start = 1'b0;
    if (note_idx !== 5'd1 || mistakes !== 8'd0 || busy !== 1'b1) begin
      $display("FAIL busy_start idx=%0d miss=%0d busy=%0b exp 1 0 1", note_idx, mistakes, busy);
      bad++;
    end
    total++;
    for (int i = 0; i < 300; i++) begin
      note = (i % 2 == 0) ? C4 : D;
      cyc();
    end
    note = NONE;
    cyc();
    if (mistakes !== 8'd255) begin
      $display("FAIL miss_saturate got=%0d exp=255", mistakes);
      bad++;
    end
    total++;
    // song 0 still latched: idx1 expects E (song 3 would expect F)
    play(E);
    if (note_idx !== 5'd2 || mistakes !== 8'd255) begin
      $display("FAIL song_kept idx=%0d miss=%0d exp 2 255", note_idx, mistakes);
      bad++;
    end
    total++;
    do_abort();
  endtask

  task automatic test_hint();
    logic [7:0] exp_led;
    begin_song(2'd3);
    cyc();
    for (int k = 1; k <= 12; k++) begin
      TICK = 1'b1;
      cyc();
      TICK = 1'b0;
      cyc();
`ifdef HINT_BLINK_EN
      exp_led = (k >= 9 && ((k - 8) % 2 == 1)) ? 8'h00 : 8'h10;
`else
      exp_led = 8'h10;
`endif
      if (Led !== exp_led) begin
        $display("FAIL hint_led tick=%0d got=%h exp=%h", k, Led, exp_led);
        bad++;
      end
      total++;
    end
    TICK = 1'b1;
    cyc();
    TICK = 1'b0;
    note = G;
    cyc();
    cyc();
    if (Led !== 8'h10 || busy !== 1'b1) begin
      $display("FAIL hint_pressed led=%h busy=%0b exp 10 1", Led, busy);
      bad++;
    end
    total++;
    note = NONE;
    do_abort();
  endtask

  initial begin
    test_reset();
    test_reset_mid_lesson();
    test_full_song2();
    test_back_to_back();
    test_mistakes();
    test_abort_at_end();
    test_busy_start_saturate();
    test_hint();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
